pixel_coef_multiplier: RTL and testbench



---
 rtl/pixel_coef_multiplier.sv | 55 +++++
 tb/tb_pixel_coef_multiplier.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pixel_coef_multiplier.sv
// pixel_coef_multiplier: shift-add multiply prod1 = pixel * coef; start accepted in IDLE, busy in CALC/DONE, done pulses one cycle, prod1 held until next completion
module pixel_coef_multiplier #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PIX_W-1:0]        pixel,
  input  logic [COEF_W-1:0]       coef,
  output logic                    busy,
  output logic                    done,
  output logic [PIX_W+COEF_W-1:0] prod1
);
  localparam int W  = PIX_W + COEF_W;
  localparam int CW = $clog2(PIX_W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [PIX_W-1:0] mplier_q, mplier_d;
  logic [W-1:0]     mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             go, calc, last;
  always_comb begin
    go       = state_q == IDLE && start;
    calc     = state_q == CALC;
    last     = cnt_q == CW'(PIX_W - 1);
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    state_d  = state_q == IDLE ? (start ? CALC : IDLE) : calc ? (last ? DONE : CALC) : IDLE;
    mplier_d = go ? pixel : calc ? mplier_q >> 1 : mplier_q;
    mcand_d  = go ? W'(coef) : calc ? mcand_q << 1 : mcand_q;
    acc_d    = go ? '0 : calc ? sum : acc_q;
    cnt_d    = go ? '0 : calc ? cnt_q + 1'b1 : cnt_q;
    prod_d   = calc && last ? sum : prod_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end
  assign busy  = state_q != IDLE;
  assign done  = state_q == DONE;
  assign prod1 = prod_q;
endmodule

// File: tb/tb_pixel_coef_multiplier.sv
// tb_pixel_coef_multiplier: timeline model plus directed literal checks for pixel_coef_multiplier
module tb_pixel_coef_multiplier;
  logic        clk = 0, rst = 1, start = 0;
  logic [7:0]  pixel = 0;
  logic [13:0] coef = 0;
  logic        busy, done;
  logic [21:0] prod1;
  int n_checks = 0, n_fail = 0, n_done = 0;
  int m_cnt = 0, m_prod = 0, m_a = 0, m_b = 0;
  bit chk_en = 0;
  pixel_coef_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .pixel(pixel), .coef(coef),
    .busy(busy), .done(done), .prod1(prod1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: an accepted request makes the block busy for 9 cycles, the last being the done cycle
  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_prod <= 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt <= 9;
        m_a   <= int'(pixel);
        m_b   <= int'(coef);
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) m_prod <= m_a * m_b;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_cnt != 0));
      chk("done", int'(done), int'(m_cnt == 1));
      chk("prod1", int'(prod1), m_prod);
    end
    if (done) n_done++;
  end
  task automatic op(input int a, input int b, input int exp);
    int lat;
    pixel = 8'(a);
    coef  = 14'(b);
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 9);
    chk("product", int'(prod1), exp);
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int d0, a, b;
    start = 1;
    pixel = 8'd9;
    coef  = 14'd9;
    repeat (2) @(negedge clk);
    rst   = 0;
    start = 0;
    chk_en = 1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_prod1", int'(prod1), 0);
    op(200, 5000, 1000000);
    chk("idle_after", int'(busy), 0);
    op(255, 16383, 4177665);
    op(0, 16383, 0);
    op(1, 1, 1);
    op(255, 0, 0);
    d0 = n_done;
    pixel = 8'd10;
    coef  = 14'd10;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    pixel = 8'd99;
    coef  = 14'd99;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    pixel = 8'd50;
    coef  = 14'd50;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    chk("ignore_prod", int'(prod1), 100);
    chk("ignore_ndone", n_done - d0, 1);
    d0 = n_done;
    pixel = 8'd3;
    coef  = 14'd7;
    start = 1;
    for (int i = 0; i < 40; i++) @(negedge clk);
    start = 0;
    chk("hold_ndone", n_done - d0, 4);
    chk("hold_prod", int'(prod1), 21);
    @(negedge clk);
    pixel = 8'd100;
    coef  = 14'd100;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_prod1", int'(prod1), 0);
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("midrst_ndone", n_done - d0, 0);
    op(2, 3, 6);
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(255));
      b = int'($urandom_range(16383));
      op(a, b, a * b);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
